shift_left_pipe: RTL
====================

Name: shift_left_pipe

Overview:
- Pipelined 16-bit left shifter for the ALU shift path. Implements SLL and ROL and complements the existing right-shift stages.
- Four registered stages, one per shift-amount bit: stage k shifts by 2^k when shamt[k]=1.
- Valid/ready handshake on both sides. Per-stage bubble collapsing, so the block sustains one result per cycle.

Parameters:
- WIDTH, 16, data width. Only 16 is supported.
- STAGES, 4, number of pipeline stages. Fixed at log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- in_data  input  16  operand
- in_shamt  input  4  shift amount, 0..15
- in_mode  input  1  0 = SLL (fill with zeros), 1 = ROL (rotate left)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  16  shifted result

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All stage valid bits clear, so out_valid=0 and out_data=16'h0000.
  - in_ready=1 as soon as reset releases.
  - Data, shamt and mode registers reset to 0.
- Transfers:
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - in_valid, in_data, in_shamt and in_mode are sampled only on an input transfer.
- Stage k (k=0..3):
  - Holds v_k, d_k, s_k (remaining shamt) and m_k (mode).
  - On load it computes d = s[k] ? (d << 2^k | (m ? d >> (16-2^k) : 0)) : d, truncated to 16 bits.
  - Stage 0 takes its operands from the in_* ports; stage k takes them from stage k-1.
- Ready chain (combinational, from the output back to the input):
  - rdy_3 = !v_3 || out_ready
  - rdy_k = !v_k || rdy_{k+1}
  - in_ready = rdy_0
- Stage k loads when rdy_k is 1.
  - It takes the upstream payload and valid bit: in_valid for stage 0, v_{k-1} for later stages.
  - An invalid upstream value loads as a bubble (v_k=0), and the data fields may update freely.
  - When rdy_k=0, stage k holds all of its fields.
- Latency:
  - With no backpressure, the result appears exactly 4 cycles after the input transfer: out_valid is high in cycle N+4 for a transfer in cycle N.
  - Throughput is 1 result per cycle.
- Bubble collapsing: a stall at the output fills empty downstream stages first. Up to 4 results are held before in_ready drops.
- Ordering: results leave in strict input order. No transfer is dropped or duplicated.
- Boundary conditions:
  - shamt=0 gives out_data=in_data.
  - shamt=15 with SLL gives {in_data[0],15'b0}.
  - ROL by any amount preserves the popcount of the operand.
- Simultaneous input and output transfer with the pipe full: allowed, and the contents shift forward by one stage.
- out_valid && !out_ready: out_data and out_valid stay stable until the output transfer.
- Reset mid-operation: all in-flight requests are discarded immediately and nothing is emitted after reset.
- No X propagation: the data registers are reset.

Decomposition:
- Shared package (shift_pkg):
  - DATA_W=16 and SHAMT_W=4.
  - Mode encoding: MODE_SLL=1'b0, MODE_ROL=1'b1.
  - Stage payload struct {data, shamt, mode}.
- Sub-module shl_stage (parameter K):
  - Combinational shift-by-2^K with rotate fill, built from one mux2x1 per bit.
  - Instantiated 4 times; the pipeline registers live in the top module.

Test Plan:
- Reset then idle: after rst_n rises, in_ready=1 and out_valid=0. Assert rst_n=0 mid-stream with 3 requests in flight → out_valid=0 immediately, and no result appears after release.
- Single SLL with no backpressure: in_data=16'h00F1, shamt=4, mode=0, out_ready=1 → out_data=16'h0F10 with out_valid high exactly 4 cycles later. Edge values:
  - shamt=0 on 16'hA5A5 → 16'hA5A5.
  - shamt=15 on 16'h0003 → 16'h8000.
- ROL sweep: in_data=16'h8001, mode=1, shamt=0..15 → each result equals the rotate-left of 16'h8001 by shamt. Example: shamt=1 → 16'h0003, shamt=15 → 16'hC000.
- Full throughput: 16 back-to-back requests with out_ready=1 → 16 consecutive out_valid cycles, in order, in_ready never low.
- Backpressure: hold out_ready=0 while streaming → exactly 4 requests accepted, then in_ready=0 with out_data stable. Release → results drain in order, and in_ready recovers in the same cycle as the first output transfer.
- Bubbles: random in_valid (50%) and random out_ready (50%) over 2000 transactions → scoreboard matches a reference model with no loss, duplication or reordering.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the pipelined 16-bit left shifter (SLL / ROL).
package shift_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic MODE_SLL = 1'b0;
  localparam logic MODE_ROL = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               mode;
  } stage_t;

  function automatic logic mux2x1(input logic a, input logic b, input logic sel);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/shift_left_pipe_if.sv
// Request/result handshake bundle of the left shifter; master drives requests, slave is the shifter.
interface shift_left_pipe_if;
  import shift_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shl_stage.sv
// Combinational conditional shift by 2^K; vacated low bits take zeros (SLL) or the wrapped top bits (ROL).
module shl_stage
  import shift_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [DATA_W-1:0] d_i,
  input  logic              sel_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] d_o
);

  localparam int S = 1 << K;

  logic [DATA_W-1:0] shifted;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    if (i >= S) begin : g_move
      assign shifted[i] = d_i[i-S];
    end else begin : g_fill
      assign shifted[i] = (mode_i == MODE_ROL) & d_i[DATA_W-S+i];
    end
    assign d_o[i] = mux2x1(d_i[i], shifted[i], sel_i);
  end

endmodule

// File: rtl/shift_left_pipe.sv
// Four-stage pipelined 16-bit left shifter (SLL/ROL) with valid/ready and per-stage bubble collapsing.
// Only WIDTH=16 / STAGES=4 is supported.
module shift_left_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_left_pipe_if.slave  bus
);

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  stage_t            pl_q [STAGES];
  stage_t            pl_d [STAGES];
  stage_t            up   [STAGES];
  logic [DATA_W-1:0] shf  [STAGES];
  logic [WIDTH-1:0]  res;

  always_comb begin
    up[0]   = {bus.in_data, bus.in_shamt, bus.in_mode};
    up_v[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      up[k]   = pl_q[k-1];
      up_v[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Flattened ready chain: stage k can load if any stage from k to the output is empty, or the consumer takes.
    assign rdy[k] = bus.out_ready | ~(&v_q[STAGES-1:k]);

    shl_stage #(.K(k)) u_shl (
      .d_i    (up[k].data),
      .sel_i  (up[k].shamt[k]),
      .mode_i (up[k].mode),
      .d_o    (shf[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]  = v_q[k];
      pl_d[k] = pl_q[k];
      if (rdy[k]) begin
        v_d[k]       = up_v[k];
        pl_d[k]      = up[k];
        pl_d[k].data = shf[k];
      end
    end
  end

  // Pipeline registers: valid and payload for every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) pl_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) pl_q[k] <= pl_d[k];
    end
  end

  assign res           = pl_q[STAGES-1].data;
  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out_data  = res;

endmodule
